// File: rtl/lfsr_target_picker.sv
// lfsr_target_picker: pseudo-random box selector for the mole/box game.
// An XNOR Fibonacci LFSR supplies candidates. A draw rejects out-of-range
// candidates and, optionally, a repeat of the previous box. If too many
// candidates are rejected, a deterministic fallback box is used instead.
module lfsr_target_picker #(
    parameter int WIDTH        = 8,
    parameter int NUM_BOXES    = 4,
    parameter int BOX_W        = 3,
    parameter int NO_REPEAT    = 1,
    parameter int MAX_TRIES    = 16,
    parameter int SEED_DEFAULT = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_signal,
    input  logic             enable,
    input  logic             reseed,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [BOX_W-1:0] box,
    output logic [WIDTH-1:0] lfsr_state
);

    // Candidate width: enough bits to address every box.
    localparam int K     = (NUM_BOXES > 2) ? $clog2(NUM_BOXES) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [WIDTH-1:0] SEED     = WIDTH'(SEED_DEFAULT);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [BOX_W-1:0] NB       = BOX_W'(NUM_BOXES);
    localparam logic [BOX_W-1:0] ONE_B    = BOX_W'(1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] cnt_q;
    logic [BOX_W-1:0] box_q, box_d;
    logic [BOX_W-1:0] last_q, last_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic             valid_q, valid_d;

    logic             fb;
    logic [K-1:0]     cand;
    logic [BOX_W-1:0] cand_box;
    logic [BOX_W-1:0] fallback_box;
    logic             cand_ok;

    // Feedback taps per width (1-based tap n is bit n-1). XNOR form keeps
    // all-zeros legal and makes all-ones the lockup state.
    if (WIDTH == 4) begin : g_fb_w4
        assign fb = ~(lfsr_q[3] ^ lfsr_q[2]);
    end else if (WIDTH == 5) begin : g_fb_w5
        assign fb = ~(lfsr_q[4] ^ lfsr_q[2]);
    end else if (WIDTH == 6) begin : g_fb_w6
        assign fb = ~(lfsr_q[5] ^ lfsr_q[4]);
    end else if (WIDTH == 7) begin : g_fb_w7
        assign fb = ~(lfsr_q[6] ^ lfsr_q[5]);
    end else begin : g_fb_w8
        assign fb = ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]);
    end

    // The candidate uses the pre-step LFSR value. Box numbers are 1-based,
    // and a previous box of 0 means nothing has been drawn yet.
    assign cand         = lfsr_q[K-1:0];
    assign cand_box     = BOX_W'(cand) + ONE_B;
    assign cand_ok      = (BOX_W'(cand) < NB) &&
                          ((NO_REPEAT == 0) || (last_q == '0) || (cand_box != last_q));
    assign fallback_box = (last_q == NB) ? ONE_B : (last_q + ONE_B);

    // LFSR next value: reseed wins over a step and never loads the lockup value.
    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed) begin
            lfsr_d = (cnt_q == ALL_ONES) ? SEED : cnt_q;
        end else if ((state_q == DRAW) || enable) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], fb};
        end
    end

    // Draw FSM: IDLE waits for req; DRAW tests one candidate per edge.
    always_comb begin
        state_d = state_q;
        try_d   = try_q;
        box_d   = box_q;
        last_d  = last_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    try_d   = '0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    box_d   = cand_box;
                    last_d  = cand_box;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (try_q == TRY_LAST) begin
                    box_d   = fallback_box;
                    last_d  = fallback_box;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    try_d = try_q + TRY_ONE;
                end
            end
        endcase
    end

    // State registers. Reset is asynchronous and aborts any draw in progress.
    always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
        if (reset_signal) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            box_q   <= '0;
            last_q  <= '0;
            try_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_q + CNT_ONE;
            box_q   <= box_d;
            last_q  <= last_d;
            try_q   <= try_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = (state_q == DRAW);
    assign valid      = valid_q;
    assign box        = box_q;
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_target_picker.sv
// Testbench for lfsr_target_picker: four differently configured instances
// run in lockstep against a behavioural model, plus directed scenarios.
module tb_lfsr_target_picker;

    localparam int N = 4;
    // Instance configurations: width, boxes, no-repeat, max tries.
    localparam int CW  [N] = '{4, 4, 4, 8};
    localparam int CNB [N] = '{3, 3, 2, 4};
    localparam int CNR [N] = '{0, 1, 1, 1};
    localparam int CMT [N] = '{16, 2, 16, 16};

    logic       CLOCK_50;
    logic       reset_signal;
    logic       en     [N];
    logic       rs     [N];
    logic       rq     [N];
    logic       busy_w [N];
    logic       valid_w[N];
    logic [2:0] box_w  [N];
    logic [3:0] ls0, ls1, ls2;
    logic [7:0] ls3;

    int n_tests;
    int n_fail;

    // Model state.
    int m_lfsr [N];
    int m_cnt  [N];
    int m_tries[N];
    int m_box  [N];
    int m_last [N];
    int m_draw [N];
    int m_valid[N];

    lfsr_target_picker #(.WIDTH(4), .NUM_BOXES(3), .BOX_W(3), .NO_REPEAT(0),
                         .MAX_TRIES(16), .SEED_DEFAULT(1)) u_d0 (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .enable(en[0]),
        .reseed(rs[0]), .req(rq[0]), .busy(busy_w[0]), .valid(valid_w[0]),
        .box(box_w[0]), .lfsr_state(ls0));

    lfsr_target_picker #(.WIDTH(4), .NUM_BOXES(3), .BOX_W(3), .NO_REPEAT(1),
                         .MAX_TRIES(2), .SEED_DEFAULT(1)) u_d1 (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .enable(en[1]),
        .reseed(rs[1]), .req(rq[1]), .busy(busy_w[1]), .valid(valid_w[1]),
        .box(box_w[1]), .lfsr_state(ls1));

    lfsr_target_picker #(.WIDTH(4), .NUM_BOXES(2), .BOX_W(3), .NO_REPEAT(1),
                         .MAX_TRIES(16), .SEED_DEFAULT(1)) u_d2 (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .enable(en[2]),
        .reseed(rs[2]), .req(rq[2]), .busy(busy_w[2]), .valid(valid_w[2]),
        .box(box_w[2]), .lfsr_state(ls2));

    lfsr_target_picker #(.WIDTH(8), .NUM_BOXES(4), .BOX_W(3), .NO_REPEAT(1),
                         .MAX_TRIES(16), .SEED_DEFAULT(1)) u_d3 (
        .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .enable(en[3]),
        .reseed(rs[3]), .req(rq[3]), .busy(busy_w[3]), .valid(valid_w[3]),
        .box(box_w[3]), .lfsr_state(ls3));

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_lfsr(input int i);
        case (i)
            0:       return int'(ls0);
            1:       return int'(ls1);
            2:       return int'(ls2);
            default: return int'(ls3);
        endcase
    endfunction

    // One LFSR step from the tap list: shift left, feed in the XNOR of the taps.
    function automatic int lfsr_next(input int v, input int w);
        int mask;
        int p;
        case (w)
            4:       mask = 'h0C;
            5:       mask = 'h14;
            6:       mask = 'h30;
            7:       mask = 'h60;
            default: mask = 'hB8;
        endcase
        p = $countones(v & mask) % 2;
        return ((v << 1) | (1 - p)) & ((1 << w) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lfsr[i]  = 1;
            m_cnt[i]   = 0;
            m_tries[i] = 0;
            m_box[i]   = 0;
            m_last[i]  = 0;
            m_draw[i]  = 0;
            m_valid[i] = 0;
        end
    endtask

    // Advance the model of instance i by one clock edge.
    task automatic model_edge(input int i);
        int w;
        int all1;
        int k;
        int c;
        int nl;
        w    = CW[i];
        all1 = (1 << w) - 1;
        if (rs[i])
            nl = (m_cnt[i] == all1) ? 1 : m_cnt[i];
        else if (m_draw[i] != 0 || en[i])
            nl = lfsr_next(m_lfsr[i], w);
        else
            nl = m_lfsr[i];
        m_valid[i] = 0;
        if (m_draw[i] == 0) begin
            if (rq[i]) begin
                m_draw[i]  = 1;
                m_tries[i] = 0;
            end
        end else begin
            k = 1;
            while ((1 << k) < CNB[i]) k++;
            c = m_lfsr[i] % (1 << k);
            if (c < CNB[i] && (CNR[i] == 0 || m_last[i] == 0 || c + 1 != m_last[i])) begin
                m_box[i]   = c + 1;
                m_last[i]  = c + 1;
                m_valid[i] = 1;
                m_draw[i]  = 0;
            end else if (m_tries[i] == CMT[i] - 1) begin
                m_box[i]   = (m_last[i] % CNB[i]) + 1;
                m_last[i]  = m_box[i];
                m_valid[i] = 1;
                m_draw[i]  = 0;
            end else begin
                m_tries[i]++;
            end
        end
        m_lfsr[i] = nl;
        m_cnt[i]  = (m_cnt[i] + 1) % (1 << w);
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("busy_%0d", i),  int'(busy_w[i]),  m_draw[i]);
            chk($sformatf("valid_%0d", i), int'(valid_w[i]), m_valid[i]);
            chk($sformatf("box_%0d", i),   int'(box_w[i]),   m_box[i]);
            chk($sformatf("lfsr_%0d", i),  dut_lfsr(i),      m_lfsr[i]);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        for (int i = 0; i < N; i++) model_edge(i);
        @(negedge CLOCK_50);
        check_all();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0;
            rs[i] = 1'b0;
            rq[i] = 1'b0;
        end
    endtask

    int exp_seq [15] = '{3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8, 0, 1};
    int nval;
    int prev_box;
    int guard;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        reset_signal = 1'b1;
        model_reset();

        // Reset state.
        #5;
        check_all();
        chk("rst_lfsr", int'(ls0), 1);
        chk("rst_box", int'(box_w[0]), 0);
        @(negedge CLOCK_50);
        reset_signal = 1'b0;

        // Test 1: outputs hold with everything low.
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("t1_lfsr_hold", int'(ls0), 1);
            chk("t1_busy", int'(busy_w[0]), 0);
        end

        // Test 2: full 15-step period of the 4-bit sequence.
        en[0] = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
            chk($sformatf("t2_seq_%0d", n), int'(ls0), exp_seq[n]);
            chk("t2_no_lockup", int'(ls0 != 4'hF), 1);
        end
        en[0] = 1'b0;

        // Test 3 (instance 0) and fallback test 5 (instance 1) side by side.
        rq[0] = 1'b1;
        rq[1] = 1'b1;
        tick();
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        chk("t3_busy_e1", int'(busy_w[0]), 1);
        chk("t3_valid_e1", int'(valid_w[0]), 0);
        tick();
        chk("t3_valid_e2", int'(valid_w[0]), 1);
        chk("t3_box_first", int'(box_w[0]), 2);
        chk("t5_box_first", int'(box_w[1]), 2);
        tick();
        chk("t3_valid_pulse", int'(valid_w[0]), 0);
        rq[0] = 1'b1;
        rq[1] = 1'b1;
        tick();
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        chk("t3_busy_d1", int'(busy_w[0]), 1);
        tick();
        chk("t3_busy_d2", int'(busy_w[0]), 1);
        tick();
        chk("t3_busy_d3", int'(busy_w[0]), 1);
        chk("t5_fallback_valid", int'(valid_w[1]), 1);
        chk("t5_fallback_box", int'(box_w[1]), 3);
        tick();
        chk("t3_valid_e4", int'(valid_w[0]), 1);
        chk("t3_box_second", int'(box_w[0]), 3);
        chk("t3_busy_done", int'(busy_w[0]), 0);

        // Test 4: back-to-back draws with no-repeat over two boxes.
        rq[2]    = 1'b1;
        nval     = 0;
        prev_box = 0;
        guard    = 0;
        while (nval < 50 && guard < 2000) begin
            tick();
            guard++;
            if (valid_w[2]) begin
                nval++;
                chk("t4_range", int'(box_w[2] >= 3'd1 && box_w[2] <= 3'd2), 1);
                if (nval > 1) chk("t4_alternate", int'(int'(box_w[2]) != prev_box), 1);
                prev_box = int'(box_w[2]);
            end
        end
        chk("t4_valid_count", nval, 50);
        rq[2] = 1'b0;
        tick();
        tick();

        // Test 6: reseed from the free counter.
        guard = 0;
        while (m_cnt[0] != 15 && guard < 20) begin
            tick();
            guard++;
        end
        rs[0] = 1'b1;
        tick();
        rs[0] = 1'b0;
        chk("t6_reseed_lockup", int'(ls0), 1);
        guard = 0;
        while (m_cnt[0] != 5 && guard < 20) begin
            tick();
            guard++;
        end
        rs[0] = 1'b1;
        tick();
        rs[0] = 1'b0;
        chk("t6_reseed_5", int'(ls0), 5);

        // Reset in the middle of a draw.
        rq[0] = 1'b1;
        tick();
        rq[0] = 1'b0;
        chk("t6_busy_before_rst", int'(busy_w[0]), 1);
        reset_signal = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy_w[0]), 0);
        chk("t6_rst_valid", int'(valid_w[0]), 0);
        chk("t6_rst_box", int'(box_w[0]), 0);
        model_reset();
        check_all();
        #4;
        reset_signal = 1'b0;

        // req while busy is ignored.
        rq[0] = 1'b1;
        tick();
        rq[0] = 1'b0;
        tick();
        chk("t6_box_pre", int'(box_w[0]), 2);
        rq[0] = 1'b1;
        tick();
        rq[0] = 1'b0;
        nval = 0;
        tick();
        if (valid_w[0]) nval++;
        rq[0] = 1'b1;
        tick();
        rq[0] = 1'b0;
        if (valid_w[0]) nval++;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (valid_w[0]) nval++;
        end
        chk("t6_busy_req_ignored", nval, 1);

        // Randomised traffic on all instances.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = 1'($urandom_range(0, 1));
                rs[i] = ($urandom_range(0, 39) == 0);
                rq[i] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
